// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
//   owner_e  : which requester owns a memory access (core or external port)
//   rd_tag_t : read-return tag {valid, owner} carried through the latency pipe
package dmem_arb_pkg;

   typedef enum logic {
      OWNER_CORE = 1'b0,
      OWNER_EXT  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rd_tag_t;

   localparam int unsigned TAG_W        = 2;
   localparam int unsigned RD_LAT_DEF   = 1;
   localparam int unsigned MAX_LOCK_DEF = 8;
   // Wide enough for MAX_LOCK up to 255
   localparam int unsigned LOCK_W       = 8;

endpackage

// File: rtl/rd_return_pipe.sv
// rd_return_pipe: RD_LAT-deep shift register of read-return tags. A tag pushed
// in the cycle a read is granted leaves the pipe in the cycle the memory
// presents that read's data.
//   clk, rst_n  : clock, asynchronous active-low reset (clears in-flight tags)
//   push_valid  : a read is granted this cycle
//   push_owner  : owner of that read
//   pop_tag     : tag aligned with the memory's read data this cycle
module rd_return_pipe
   import dmem_arb_pkg::*;
#(
   parameter int unsigned RD_LAT = RD_LAT_DEF
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push_valid,
   input  owner_e  push_owner,
   output rd_tag_t pop_tag
);

   logic [TAG_W-1:0] stage [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < RD_LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= {push_valid, push_owner};
         for (int unsigned i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign pop_tag = rd_tag_t'(stage[RD_LAT-1]);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data_memory between the core load/store
// port and an external requester. Round-robin per cycle, optional external
// lock for bursts of up to MAX_LOCK back-to-back external grants. The granted
// requester drives the memory in the same cycle; read data is routed back to
// its owner after RD_LAT cycles.
//   Core side : CORE_MEM_READ/WRITE, CORE_ADDR, CORE_WDATA -> CORE_RDATA, CORE_STALL
//   Ext side  : EXT_REQ/WE/LOCK, EXT_ADDR, EXT_WDATA -> EXT_GNT, EXT_RVALID, EXT_RDATA
//   Memory    : MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA <- MEM_RDATA
// Optional: define DMEM_ARB_STATS_EN to add saturating STALL_CNT / EXT_CNT.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned RD_LAT   = RD_LAT_DEF,
   parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              CORE_MEM_READ,
   input  logic              CORE_MEM_WRITE,
   input  logic [ADDR_W-1:0] CORE_ADDR,
   input  logic [DATA_W-1:0] CORE_WDATA,
   output logic [DATA_W-1:0] CORE_RDATA,
   output logic              CORE_STALL,
   input  logic              EXT_REQ,
   input  logic              EXT_WE,
   input  logic              EXT_LOCK,
   input  logic [ADDR_W-1:0] EXT_ADDR,
   input  logic [DATA_W-1:0] EXT_WDATA,
   output logic              EXT_GNT,
   output logic              EXT_RVALID,
   output logic [DATA_W-1:0] EXT_RDATA,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]       STALL_CNT,
   output logic [31:0]       EXT_CNT
`endif
);

   localparam logic [LOCK_W-1:0] LOCK_RELOAD = LOCK_W'(MAX_LOCK - 1);

   owner_e            last_owner;
   logic [LOCK_W-1:0] lock_cnt;
   logic              core_req;
   logic              core_gnt;
   logic              ext_gnt;
   rd_tag_t           ret_tag;

   assign core_req = CORE_MEM_READ | CORE_MEM_WRITE;

   // Lock or round-robin only matters on a tie
   always_comb begin
      core_gnt = 1'b0;
      ext_gnt  = 1'b0;
      if (core_req && EXT_REQ) begin
         if (lock_cnt != '0 || last_owner == OWNER_CORE) ext_gnt  = 1'b1;
         else                                            core_gnt = 1'b1;
      end else if (core_req) begin
         core_gnt = 1'b1;
      end else if (EXT_REQ) begin
         ext_gnt = 1'b1;
      end
   end

   assign CORE_STALL = RST_n & core_req & ~core_gnt;
   assign EXT_GNT    = RST_n & EXT_REQ & ext_gnt;

   always_comb begin
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      MEM_ADDR  = '0;
      MEM_WDATA = '0;
      if (RST_n) begin
         if (core_gnt) begin
            MEM_WRITE = CORE_MEM_WRITE;
            MEM_READ  = CORE_MEM_READ & ~CORE_MEM_WRITE;
            MEM_ADDR  = CORE_ADDR;
            MEM_WDATA = CORE_WDATA;
         end else if (ext_gnt) begin
            MEM_WRITE = EXT_WE;
            MEM_READ  = ~EXT_WE;
            MEM_ADDR  = EXT_ADDR;
            MEM_WDATA = EXT_WDATA;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         last_owner <= OWNER_CORE;
         lock_cnt   <= '0;
      end else begin
         if (core_gnt)     last_owner <= OWNER_CORE;
         else if (ext_gnt) last_owner <= OWNER_EXT;

         if (!EXT_REQ || !EXT_LOCK) lock_cnt <= '0;
         else if (ext_gnt)          lock_cnt <= (lock_cnt == '0) ? LOCK_RELOAD
                                                                 : lock_cnt - LOCK_W'(1);
      end
   end

   rd_return_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_return_pipe (
      .clk        (CLK),
      .rst_n      (RST_n),
      .push_valid (MEM_READ),
      .push_owner (ext_gnt ? OWNER_EXT : OWNER_CORE),
      .pop_tag    (ret_tag)
   );

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         CORE_RDATA <= '0;
         EXT_RDATA  <= '0;
         EXT_RVALID <= 1'b0;
      end else begin
         EXT_RVALID <= 1'b0;
         if (ret_tag.valid) begin
            if (ret_tag.owner == OWNER_EXT) begin
               EXT_RDATA  <= MEM_RDATA;
               EXT_RVALID <= 1'b1;
            end else begin
               CORE_RDATA <= MEM_RDATA;
            end
         end
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         STALL_CNT <= '0;
         EXT_CNT   <= '0;
      end else begin
         if (CORE_STALL && STALL_CNT != '1) STALL_CNT <= STALL_CNT + 32'd1;
         if (EXT_GNT && EXT_CNT != '1)      EXT_CNT   <= EXT_CNT + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter (RD_LAT=2, MAX_LOCK=8).
// Contains a behavioural data_memory stub on the memory port, a spec-level
// reference model driven alongside the stimulus, and a monitor that pops
// expected grants and read returns and compares them against the DUT.
// With DMEM_ARB_STATS_EN defined the statistics counters are also checked.
module tb_dmem_arbiter;

   localparam int unsigned RD_LAT   = 2;
   localparam int unsigned MAX_LOCK = 8;

   logic        clk = 1'b0;
   logic        RST_n;
   logic        CORE_MEM_READ, CORE_MEM_WRITE;
   logic [31:0] CORE_ADDR, CORE_WDATA, CORE_RDATA;
   logic        CORE_STALL;
   logic        EXT_REQ, EXT_WE, EXT_LOCK;
   logic [31:0] EXT_ADDR, EXT_WDATA, EXT_RDATA;
   logic        EXT_GNT, EXT_RVALID;
   logic        MEM_READ, MEM_WRITE;
   logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
`ifdef DMEM_ARB_STATS_EN
   logic [31:0] STALL_CNT, EXT_CNT;
`endif

   dmem_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RD_LAT   (RD_LAT),
      .MAX_LOCK (MAX_LOCK)
   ) dut (
      .CLK            (clk),
      .RST_n          (RST_n),
      .CORE_MEM_READ  (CORE_MEM_READ),
      .CORE_MEM_WRITE (CORE_MEM_WRITE),
      .CORE_ADDR      (CORE_ADDR),
      .CORE_WDATA     (CORE_WDATA),
      .CORE_RDATA     (CORE_RDATA),
      .CORE_STALL     (CORE_STALL),
      .EXT_REQ        (EXT_REQ),
      .EXT_WE         (EXT_WE),
      .EXT_LOCK       (EXT_LOCK),
      .EXT_ADDR       (EXT_ADDR),
      .EXT_WDATA      (EXT_WDATA),
      .EXT_GNT        (EXT_GNT),
      .EXT_RVALID     (EXT_RVALID),
      .EXT_RDATA      (EXT_RDATA),
      .MEM_READ       (MEM_READ),
      .MEM_WRITE      (MEM_WRITE),
      .MEM_ADDR       (MEM_ADDR),
      .MEM_WDATA      (MEM_WDATA),
      .MEM_RDATA      (MEM_RDATA)
`ifdef DMEM_ARB_STATS_EN
      ,
      .STALL_CNT      (STALL_CNT),
      .EXT_CNT        (EXT_CNT)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_word(input int unsigned i);
      return 32'h1357_0000 + i * 32'h0001_0203;
   endfunction

   // data_memory stub: RD_LAT-cycle read latency, write on the clock edge
   logic [31:0] mem_arr [64];
   logic [31:0] rd_pipe [RD_LAT];
   logic        mem_init = 1'b0;

   always @(posedge clk) begin
      rd_pipe[0] <= MEM_READ ? mem_arr[MEM_ADDR[7:2]] : 32'h0;
      for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
         mem_init <= 1'b1;
      end else if (MEM_WRITE) begin
         mem_arr[MEM_ADDR[7:2]] <= MEM_WDATA;
      end
   end
   assign MEM_RDATA = rd_pipe[RD_LAT-1];

   // Reference model state and scoreboard queues
   typedef struct packed {
      logic        stall;
      logic        gnt;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   typedef struct packed {
      int unsigned due;
      logic [31:0] data;
   } ret_t;

   exp_t        gnt_q [$];
   ret_t        ext_q [$];
   ret_t        core_q [$];
   logic [31:0] ref_mem [64];
   bit          m_last_ext;
   int          m_lock;
   logic [31:0] exp_core = '0;

   // Monitor: compares everything the DUT presents against the queues
   always @(negedge clk) begin
      exp_t e;
      ret_t r;
      bit   exp_v;
      if (!RST_n) begin
         exp_core = '0;
         check("rst_core_stall", {31'b0, CORE_STALL}, 32'd0);
         check("rst_ext_gnt",    {31'b0, EXT_GNT},    32'd0);
         check("rst_mem_read",   {31'b0, MEM_READ},   32'd0);
         check("rst_mem_write",  {31'b0, MEM_WRITE},  32'd0);
         check("rst_ext_rvalid", {31'b0, EXT_RVALID}, 32'd0);
      end else begin
         if (gnt_q.size() != 0) begin
            e = gnt_q.pop_front();
            check("core_stall", {31'b0, CORE_STALL}, {31'b0, e.stall});
            check("ext_gnt",    {31'b0, EXT_GNT},    {31'b0, e.gnt});
            check("mem_read",   {31'b0, MEM_READ},   {31'b0, e.rd});
            check("mem_write",  {31'b0, MEM_WRITE},  {31'b0, e.wr});
            if (e.rd || e.wr) check("mem_addr", MEM_ADDR, e.addr);
            if (e.wr)         check("mem_wdata", MEM_WDATA, e.wdata);
         end
         if (core_q.size() != 0 && core_q[0].due == cyc) begin
            r = core_q.pop_front();
            exp_core = r.data;
         end
         check("core_rdata", CORE_RDATA, exp_core);
         exp_v = (ext_q.size() != 0) && (ext_q[0].due == cyc);
         check("ext_rvalid", {31'b0, EXT_RVALID}, {31'b0, exp_v});
         if (exp_v) begin
            r = ext_q.pop_front();
            if (EXT_RVALID) check("ext_rdata", EXT_RDATA, r.data);
         end
      end
   end

   // One bus cycle: apply inputs, predict from the arbitration rules, and
   // report the observed grant/stall for directed checks.
   task automatic cycle(input logic cr, input logic cw, input logic [31:0] ca,
                        input logic [31:0] cwd, input logic er, input logic ewe,
                        input logic el, input logic [31:0] ea, input logic [31:0] ewd,
                        output logic obs_gnt, output logic obs_stall);
      exp_t e;
      bit   creq, ext_win, core_win;
      CORE_MEM_READ = cr;  CORE_MEM_WRITE = cw; CORE_ADDR = ca; CORE_WDATA = cwd;
      EXT_REQ = er; EXT_WE = ewe; EXT_LOCK = el; EXT_ADDR = ea; EXT_WDATA = ewd;
      creq = cr | cw;
      if (creq && er) ext_win = (m_lock > 0) || !m_last_ext;
      else            ext_win = er;
      core_win = creq && !ext_win;
      e = '0;
      e.stall = creq && !core_win;
      e.gnt   = ext_win;
      if (core_win) begin
         e.wr = cw; e.rd = cr && !cw; e.addr = ca; e.wdata = cwd;
      end else if (ext_win) begin
         e.wr = ewe; e.rd = !ewe; e.addr = ea; e.wdata = ewd;
      end
      gnt_q.push_back(e);
      if (e.wr) ref_mem[e.addr[7:2]] = e.wdata;
      if (e.rd) begin
         if (ext_win) ext_q.push_back('{cyc + RD_LAT + 1, ref_mem[e.addr[7:2]]});
         else         core_q.push_back('{cyc + RD_LAT + 1, ref_mem[e.addr[7:2]]});
      end
      if (core_win)     m_last_ext = 1'b0;
      else if (ext_win) m_last_ext = 1'b1;
      if (!er || !el)   m_lock = 0;
      else if (ext_win) m_lock = (m_lock == 0) ? int'(MAX_LOCK) - 1 : m_lock - 1;
      @(negedge clk);
      obs_gnt   = EXT_GNT;
      obs_stall = CORE_STALL;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic g, s;
      for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, 0, '0, '0, g, s);
   endtask

   task automatic do_reset();
      RST_n = 1'b0;
      CORE_MEM_READ = 1'b1; CORE_MEM_WRITE = 1'b0; EXT_REQ = 1'b1; EXT_WE = 1'b0;
      EXT_LOCK = 1'b0;
      #1;
      check("rst_core_rdata_now", CORE_RDATA, 32'd0);
      check("rst_ext_rdata_now",  EXT_RDATA,  32'd0);
      check("rst_ext_rvalid_now", {31'b0, EXT_RVALID}, 32'd0);
      check("rst_stall_now",      {31'b0, CORE_STALL}, 32'd0);
      m_last_ext = 1'b0;
      m_lock     = 0;
      gnt_q.delete();
      ext_q.delete();
      core_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      RST_n = 1'b1;
      CORE_MEM_READ = 1'b0; EXT_REQ = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic g, s;
      int   gcnt, scnt;
      logic cr, cw, er, ewe, el;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      m_last_ext = 1'b0;
      m_lock     = 0;
      RST_n = 1'b0;
      CORE_MEM_READ = 0; CORE_MEM_WRITE = 0; CORE_ADDR = '0; CORE_WDATA = '0;
      EXT_REQ = 0; EXT_WE = 0; EXT_LOCK = 0; EXT_ADDR = '0; EXT_WDATA = '0;
      repeat (2) @(posedge clk);
      #1;
      RST_n = 1'b1;

      // Core-only write then read
      cycle(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, '0, '0, g, s);
      check("core_wr_stall", {31'b0, s}, 32'd0);
      cycle(1, 0, 32'h10, '0, 0, 0, 0, '0, '0, g, s);
      check("core_rd_stall", {31'b0, s}, 32'd0);
      idle(RD_LAT + 1);
      check("core_rdata_deadbeef", CORE_RDATA, 32'hDEAD_BEEF);

      // Tie with last_owner=CORE: ext first, core next cycle
      cycle(1, 0, 32'h20, '0, 1, 0, 0, 32'h24, '0, g, s);
      check("tie_ext_gnt", {31'b0, g}, 32'd1);
      check("tie_core_stall", {31'b0, s}, 32'd1);
      cycle(1, 0, 32'h20, '0, 0, 0, 0, '0, '0, g, s);
      check("tie_core_next", {31'b0, s}, 32'd0);
      idle(RD_LAT + 2);

      // Lock burst from a fresh reset
      do_reset();
      gcnt = 0; scnt = 0;
      for (int i = 0; i < int'(MAX_LOCK) + 1; i++) begin
         cycle(1, 0, 32'h40, '0, 1, 1, 1, 32'h44, 32'h0BAD_F00D + i, g, s);
         gcnt += int'(g);
         scnt += int'(s);
      end
      check("lock_ext_gnts", gcnt, MAX_LOCK);
      check("lock_stalls", scnt, MAX_LOCK);
      check("lock_core_after", {31'b0, s}, 32'd0);
      idle(1);
`ifdef DMEM_ARB_STATS_EN
      check("stats_stall_cnt", STALL_CNT, 32'd8);
      check("stats_ext_cnt", EXT_CNT, 32'd8);
`endif
      idle(RD_LAT + 1);

      // Back-to-back alternating reads
      cycle(0, 0, '0, '0, 1, 0, 0, 32'h0, '0, g, s);
      cycle(1, 0, 32'h4, '0, 0, 0, 0, '0, '0, g, s);
      cycle(0, 0, '0, '0, 1, 0, 0, 32'h8, '0, g, s);
      idle(RD_LAT + 2);
      check("alt_core_rdata", CORE_RDATA, ref_mem[1]);

      // Reset one cycle after an ext read grant drops its return
      cycle(0, 0, '0, '0, 1, 0, 0, 32'h30, '0, g, s);
      do_reset();
      cycle(1, 0, 32'h20, '0, 1, 0, 0, 32'h24, '0, g, s);
      check("post_rst_ext_wins", {31'b0, g}, 32'd1);
      idle(RD_LAT + 2);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         cr  = ($urandom_range(0, 2) == 0);
         cw  = ($urandom_range(0, 3) == 0);
         er  = ($urandom_range(0, 1) == 0);
         ewe = ($urandom_range(0, 2) == 0);
         el  = ($urandom_range(0, 2) != 0);
         cycle(cr, cw, {24'b0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
               er, ewe, el, {24'b0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, g, s);
      end
      idle(RD_LAT + 3);
      check("ext_q_drained", ext_q.size(), 32'd0);
      check("core_q_drained", core_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
